// File: rtl/ecc_smul_if.sv
// ecc_smul_if: job, add-unit and result buses of the scalar-multiply sequencer.
// master is the sequencer side, slave is the environment side.
interface ecc_smul_if #(
  parameter int W  = 6,
  parameter int KW = 6
);
  logic          in_valid;
  logic [KW-1:0] in_k;
  logic [W-1:0]  in_Px;
  logic [W-1:0]  in_Py;
  logic [W-1:0]  in_prime;
  logic [W-1:0]  in_a;
  logic          busy;
  logic          pa_valid;
  logic [W-1:0]  pa_Px;
  logic [W-1:0]  pa_Py;
  logic [W-1:0]  pa_Qx;
  logic [W-1:0]  pa_Qy;
  logic [W-1:0]  pa_prime;
  logic [W-1:0]  pa_a;
  logic          pa_out_valid;
  logic [W-1:0]  pa_Rx;
  logic [W-1:0]  pa_Ry;
  logic          out_valid;
  logic [W-1:0]  out_Rx;
  logic [W-1:0]  out_Ry;
  logic          out_inf;

  modport master (
    input  in_valid, in_k, in_Px, in_Py,
    input  in_prime, in_a,
    input  pa_out_valid, pa_Rx, pa_Ry,
    output busy, pa_valid,
    output pa_Px, pa_Py, pa_Qx, pa_Qy,
    output pa_prime, pa_a,
    output out_valid, out_Rx, out_Ry,
    output out_inf
  );

  modport slave (
    output in_valid, in_k, in_Px, in_Py,
    output in_prime, in_a,
    output pa_out_valid, pa_Rx, pa_Ry,
    input  busy, pa_valid,
    input  pa_Px, pa_Py, pa_Qx, pa_Qy,
    input  pa_prime, pa_a,
    input  out_valid, out_Rx, out_Ry,
    input  out_inf
  );
endinterface

// File: rtl/ecc_smul_ctrl.sv
// ecc_smul_ctrl: left-to-right double-and-add sequencer over an external point-add unit.
// Define ECC_INF_DETECT_EN to resolve point-at-infinity steps locally instead of issuing them.
module ecc_smul_ctrl #(
  parameter int W  = 6,
  parameter int KW = 6
) (
  input logic        clk,
  input logic        rst_n,
  ecc_smul_if.master bus
);
  localparam int IW = $clog2(KW) + 1;

  typedef logic signed [IW-1:0] idx_t;

  typedef enum logic [2:0] {
    IDLE, SCAN, DBL_ISS, DBL_WAIT,
    ADD_ISS, ADD_WAIT, DONE
  } state_t;

  state_t state_q, state_d;
  state_t dbl_next, add_next;

  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  px_q, px_d;
  logic [W-1:0]  py_q, py_d;
  logic [W-1:0]  prime_q, prime_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  rx_q, rx_d;
  logic [W-1:0]  ry_q, ry_d;
  logic          inf_q, inf_d;
  idx_t          idx_q, idx_d;
  idx_t          msb, idx_dec, dbl_idx;
  logic          kbit, last;
  logic          pa_go, out_go, is_add;

  always_comb begin
    msb = '0;
    for (int j = 0; j < KW; j++)
      if (k_q[j]) msb = idx_t'(j);
  end

  // After a doubling: add if the scanned bit is set, else move to the next bit.
  assign kbit     = k_q[idx_q[IW-2:0]];
  assign last     = (idx_q == '0);
  assign idx_dec  = idx_q - idx_t'(1);
  assign dbl_next = kbit ? ADD_ISS
                  : (last ? DONE : DBL_ISS);
  assign dbl_idx  = kbit ? idx_q : idx_dec;
  assign add_next = last ? DONE : DBL_ISS;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    px_d    = px_q;
    py_d    = py_q;
    prime_d = prime_q;
    a_d     = a_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    inf_d   = inf_q;
    idx_d   = idx_q;
    pa_go   = 1'b0;
    out_go  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          k_d     = bus.in_k;
          px_d    = bus.in_Px;
          py_d    = bus.in_Py;
          prime_d = bus.in_prime;
          a_d     = bus.in_a;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (k_q == '0) begin
          rx_d    = '0;
          ry_d    = '0;
          inf_d   = 1'b1;
          state_d = DONE;
        end else begin
          rx_d    = px_q;
          ry_d    = py_q;
          inf_d   = 1'b0;
          idx_d   = msb - idx_t'(1);
          state_d = (msb == '0) ? DONE : DBL_ISS;
        end
      end
      DBL_ISS: begin
        pa_go   = 1'b1;
        state_d = DBL_WAIT;
`ifdef ECC_INF_DETECT_EN
        if (inf_q || ry_q == '0) begin
          pa_go   = 1'b0;
          inf_d   = 1'b1;
          idx_d   = dbl_idx;
          state_d = dbl_next;
        end
`endif
      end
      DBL_WAIT: begin
        if (bus.pa_out_valid) begin
          rx_d    = bus.pa_Rx;
          ry_d    = bus.pa_Ry;
          idx_d   = dbl_idx;
          state_d = dbl_next;
        end
      end
      ADD_ISS: begin
        pa_go   = 1'b1;
        state_d = ADD_WAIT;
`ifdef ECC_INF_DETECT_EN
        if (inf_q) begin
          pa_go   = 1'b0;
          rx_d    = px_q;
          ry_d    = py_q;
          inf_d   = 1'b0;
          idx_d   = idx_dec;
          state_d = add_next;
        end else if (rx_q == px_q && ry_q != py_q) begin
          pa_go   = 1'b0;
          inf_d   = 1'b1;
          idx_d   = idx_dec;
          state_d = add_next;
        end
`endif
      end
      ADD_WAIT: begin
        if (bus.pa_out_valid) begin
          rx_d    = bus.pa_Rx;
          ry_d    = bus.pa_Ry;
          idx_d   = idx_dec;
          state_d = add_next;
        end
      end
      DONE: begin
        out_go  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      prime_q <= '0;
      a_q     <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      inf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      px_q    <= px_d;
      py_q    <= py_d;
      prime_q <= prime_d;
      a_q     <= a_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      inf_q   <= inf_d;
      idx_q   <= idx_d;
    end
  end

  assign is_add = (state_q == ADD_ISS);

  assign bus.busy     = (state_q != IDLE);
  assign bus.pa_valid = pa_go;
  assign bus.pa_Px    = pa_go ? rx_q : '0;
  assign bus.pa_Py    = pa_go ? ry_q : '0;
  assign bus.pa_Qx    = !pa_go ? '0
                      : (is_add ? px_q : rx_q);
  assign bus.pa_Qy    = !pa_go ? '0
                      : (is_add ? py_q : ry_q);
  assign bus.pa_prime = pa_go ? prime_q : '0;
  assign bus.pa_a     = pa_go ? a_q : '0;

  assign bus.out_valid = out_go;
  assign bus.out_inf   = out_go & inf_q;
  assign bus.out_Rx    = (out_go && !inf_q) ? rx_q : '0;
  assign bus.out_Ry    = (out_go && !inf_q) ? ry_q : '0;
endmodule

// File: tb/tb_ecc_smul_ctrl.sv
// tb_ecc_smul_ctrl: directed vectors on curve y^2=x^3+2x+2 mod 17, P=(5,1), order 19.
// The add-unit model looks up multiples of P and answers after 1-20 cycles.
module tb_ecc_smul_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ecc_smul_if #(.W(6), .KW(6)) bus();

  ecc_smul_ctrl #(.W(6), .KW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int k;
    int x;
    int y;
    int inf;
    int ntx;
    int skip;
  } vec_t;

  vec_t vt[11];
  int   mx[19];
  int   my[19];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int txn = 0;
  int first_pa = -1;
  int force_dly = 0;
  int lat_sum = 0;
  bit rsp_chk = 1'b0;
  int rsp_cyc = 0;
  bit pend = 1'b0;
  int cnt = 0;
  int res = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int find(input int x, input int y);
    for (int i = 0; i < 19; i++)
      if (mx[i] == x && my[i] == y) return i;
    return -1;
  endfunction

  // Add-unit model: index arithmetic on multiples of P; index 0 is (0,0).
  initial begin : model
    int j1, j2, d;
    bus.pa_out_valid = 1'b0;
    bus.pa_Rx = '0;
    bus.pa_Ry = '0;
    forever begin
      @(posedge clk); #1;
      bus.pa_out_valid = 1'b0;
      bus.pa_Rx = '0;
      bus.pa_Ry = '0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.pa_out_valid = 1'b1;
          bus.pa_Rx = 6'(mx[res]);
          bus.pa_Ry = 6'(my[res]);
          pend = 1'b0;
          rsp_chk = bus.busy;
          rsp_cyc = cyc;
        end
      end
      if (bus.pa_valid) begin
        txn++;
        if (first_pa < 0) first_pa = cyc;
        check("pa_single_outstanding", 32'(pend), 0);
        if (rsp_chk) begin
          check("pa_after_rsp", cyc, rsp_cyc + 1);
          rsp_chk = 1'b0;
        end
        check("pa_prime", 32'(bus.pa_prime), 17);
        check("pa_a", 32'(bus.pa_a), 2);
        j1 = find(int'(bus.pa_Px), int'(bus.pa_Py));
        j2 = find(int'(bus.pa_Qx), int'(bus.pa_Qy));
        check("pa_operand_known", 32'(j1 < 0 || j2 < 0), 0);
        check("pa_operand_shape", 32'(j2 == j1 || j2 == 1), 1);
        res = (j1 < 0 || j2 < 0) ? 0 : (j1 + j2) % 19;
        d = (force_dly > 0) ? force_dly : int'($urandom_range(20, 1));
        lat_sum += 1 + d;
        cnt = d;
        pend = 1'b1;
      end else begin
        check("pa_idle_zero",
              32'(|{bus.pa_Px, bus.pa_Py, bus.pa_Qx,
                    bus.pa_Qy, bus.pa_prime, bus.pa_a}), 0);
      end
    end
  end

  task automatic start(input int k);
    bus.in_valid = 1'b1;
    bus.in_k = 6'(k);
    bus.in_Px = 6'd5;
    bus.in_Py = 6'd1;
    bus.in_prime = 6'd17;
    bus.in_a = 6'd2;
  endtask

  task automatic run_job(input int k, input bit noise,
                         output int ox, output int oy,
                         output int oinf, output int lat);
    int t0;
    int extra;
    bit seen;
    seen = 1'b0;
    ox = 0; oy = 0; oinf = 0; lat = 0;
    @(posedge clk); #1;
    txn = 0;
    lat_sum = 0;
    first_pa = -1;
    rsp_chk = 1'b0;
    start(k);
    t0 = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("busy_rise", 32'(bus.busy), 1);
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      if (noise && cyc[0]) start(2);
    end
    check("out_seen", 32'(seen), 1);
    ox = int'(bus.out_Rx);
    oy = int'(bus.out_Ry);
    oinf = int'(bus.out_inf);
    lat = cyc - t0;
    check("busy_at_out", 32'(bus.busy), 1);
    if (rsp_chk) begin
      check("out_after_rsp", cyc, rsp_cyc + 1);
      rsp_chk = 1'b0;
    end
    if (k > 1) check("first_pa_lat", first_pa - t0, 2);
    @(posedge clk); #1;
    check("out_one_cycle", 32'(bus.out_valid), 0);
    check("busy_drop", 32'(bus.busy), 0);
    extra = 0;
    for (int c = 0; c < (noise ? 25 : 3); c++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) extra++;
    end
    check("no_extra_job", extra, 0);
  endtask

  initial begin : main
    int ox, oy, oinf, lat, quiet;
    bit got_pa;
    mx = '{0, 5, 6, 10, 3, 9, 16, 0, 13, 7,
           7, 13, 0, 16, 9, 3, 10, 6, 5};
    my = '{0, 1, 3, 6, 1, 16, 13, 6, 7, 6,
           11, 10, 11, 4, 1, 16, 11, 14, 16};
    vt[0]  = '{0, 0, 0, 1, 0, 0};
    vt[1]  = '{1, 5, 1, 0, 0, 0};
    vt[2]  = '{2, 6, 3, 0, 1, 0};
    vt[3]  = '{3, 10, 6, 0, 2, 0};
    vt[4]  = '{5, 9, 16, 0, 3, 0};
    vt[5]  = '{6, 16, 13, 0, 3, 0};
    vt[6]  = '{13, 16, 4, 0, 5, 0};
    vt[7]  = '{18, 5, 16, 0, 5, 0};
`ifdef ECC_INF_DETECT_EN
    vt[8]  = '{19, 0, 0, 1, 5, 1};
    vt[9]  = '{38, 0, 0, 1, 5, 2};
`else
    vt[8]  = '{19, 0, 0, 0, 6, 0};
    vt[9]  = '{38, 0, 0, 0, 7, 0};
`endif
    vt[10] = '{63, 16, 13, 0, 10, 0};

    bus.in_valid = 1'b0;
    bus.in_k = '0;
    bus.in_Px = '0;
    bus.in_Py = '0;
    bus.in_prime = '0;
    bus.in_a = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs",
          32'(|{bus.busy, bus.pa_valid, bus.out_valid,
                bus.out_inf, bus.out_Rx, bus.out_Ry}), 0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      run_job(vt[i].k, 1'b0, ox, oy, oinf, lat);
      check($sformatf("k%0d_x", vt[i].k), ox, vt[i].x);
      check($sformatf("k%0d_y", vt[i].k), oy, vt[i].y);
      check($sformatf("k%0d_inf", vt[i].k), oinf, vt[i].inf);
      check($sformatf("k%0d_txn", vt[i].k), txn, vt[i].ntx);
      check($sformatf("k%0d_lat", vt[i].k), lat,
            2 + lat_sum + vt[i].skip);
    end

    run_job(3, 1'b1, ox, oy, oinf, lat);
    check("noise_x", ox, 10);
    check("noise_y", oy, 6);
    check("noise_txn", txn, 2);

    // Abort during DBL_WAIT; the answer arrives after reset is released.
    force_dly = 10;
    txn = 0;
    @(posedge clk); #1;
    start(2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    got_pa = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.pa_valid) begin
        got_pa = 1'b1;
        break;
      end
    end
    check("rst_pa_seen", 32'(got_pa), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          32'(|{bus.busy, bus.pa_valid, bus.out_valid,
                bus.out_inf, bus.out_Rx, bus.out_Ry,
                bus.pa_Px, bus.pa_Qx}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) quiet++;
    end
    check("stale_rsp_ignored", quiet, 0);
    check("stale_txn", txn, 1);
    force_dly = 0;

    run_job(2, 1'b0, ox, oy, oinf, lat);
    check("after_rst_x", ox, 6);
    check("after_rst_y", oy, 3);
    check("after_rst_inf", oinf, 0);
    check("after_rst_txn", txn, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/ecc_smul_ctrl.md
# ecc_smul_ctrl

Scalar-multiplication sequencer for the 6-bit elliptic-curve point-addition datapath. It takes a scalar k and a point P, then runs left-to-right double-and-add to compute R = k·P. Each doubling or addition is a transaction issued to the external point-add unit over a pulse/valid handshake. Point-at-infinity cases are resolved locally, since the add unit cannot represent them.

## Interface
- W, 6, coordinate/prime/a width
- KW, 6, scalar width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle pulse; in_k/in_Px/in_Py/in_prime/in_a valid
- in_k  in  KW  scalar
- in_Px, in_Py  in  W  base point P (on curve, < prime)
- in_prime, in_a  in  W  field prime, curve coefficient a
- busy  out  1  high from cycle after accepted in_valid through out_valid cycle
- pa_valid  out  1  one-cycle issue pulse to add unit
- pa_Px, pa_Py, pa_Qx, pa_Qy, pa_prime, pa_a  out  W  add-unit operands; 0 when pa_valid low
- pa_out_valid  in  1  add-unit result strobe (one cycle)
- pa_Rx, pa_Ry  in  W  add-unit result
- out_valid  out  1  exactly one cycle per job
- out_Rx, out_Ry  out  W  result; 0 when out_valid low
- out_inf  out  1  result is point at infinity (Rx=Ry=0); 0 when out_valid low

## Operation
- States: IDLE, SCAN, DBL_ISS, DBL_WAIT, ADD_ISS, ADD_WAIT, DONE.
- IDLE: in_valid latches k, P, prime, a → SCAN. in_valid in any other state is ignored; there is no queueing.
- SCAN (1 cycle): priority-encode MSB index m of k.
  - k=0: set R=inf → DONE.
  - Otherwise: R=P, i=m-1. If i<0 → DONE, else → DBL_ISS.
- DBL_ISS: pa_valid=1, operands (R,R) → DBL_WAIT.
- DBL_WAIT: on pa_out_valid, R=(pa_Rx,pa_Ry). Then:
  - k[i]=1 → ADD_ISS.
  - Otherwise decrement i; i<0 → DONE, else → DBL_ISS.
- ADD_ISS: pa_valid=1, operands P=(R), Q=(P) → ADD_WAIT.
- ADD_WAIT: on pa_out_valid, latch R, decrement i; i<0 → DONE, else → DBL_ISS.
- DONE: out_valid=1 with R (or out_inf=1, coords 0) → IDLE; busy drops the next cycle.
- pa_out_valid is ignored outside the WAIT states. A WAIT state waits indefinitely.
- Operands pass through unchanged; no arithmetic is done here except equality compares.

## Timing
- Reset: every output is 0 and the state is IDLE, asynchronously. Reset mid-job aborts the job; no out_valid is produced, and any later pa_out_valid is ignored.
- in_valid at cycle T: SCAN at T+1, busy=1 from T+1.
  - k∈{0,1}: out_valid at T+2.
  - Otherwise: first pa_valid at T+2.
- pa_out_valid at cycle U: the next pa_valid (if any) is at U+1, or out_valid is at U+1.
- At most one transaction is outstanding; pa_valid never asserts in a WAIT state.
- Latency = 2 + Σ(1 + add-unit latency) over issued transactions.

## Configuration
- ECC_INF_DETECT_EN defined: infinity tracking is active. At each ISS state the block decides before issuing, and a skipped step takes 1 cycle and then advances as if its result had arrived.
  - DBL_ISS: R=inf → stay inf, skip. Ry=0 → R=inf, skip.
  - ADD_ISS: R=inf → R=P, skip. Rx=Px and Ry≠Py → R=inf, skip. Otherwise issue.
- ECC_INF_DETECT_EN undefined: every step is issued and no infinity tracking is done; out_inf asserts only for k=0.

## Test plan
Curve for all scenarios: p=17, a=2, P=(5,1). The bench's add-unit model returns results after a random 1-20 cycles.
- k=1 → no pa_valid, out_valid at T+2 with (5,1), out_inf=0.
- k=0 → no pa_valid, out_valid at T+2 with out_inf=1, (0,0).
- k=2 → one transaction (5,1)+(5,1); model returns (6,3); out (6,3). k=3 → second transaction (6,3)+(5,1) returns (10,6); out (10,6).
- k=19, ECC_INF_DETECT_EN defined → 4 doublings and 1 addition issued; final add 18P=(5,16)+(5,1) is skipped; out_inf=1. Without the macro → 6 transactions issued.
- in_valid pulses while busy with k=3 → ignored; exactly one out_valid, with the first job's result; out_valid is held for exactly 1 cycle.
- rst_n low during DBL_WAIT → all outputs 0 immediately. A stale pa_out_valid after release is ignored. A new job with k=2 then yields (6,3).
